execute_stage: RTL

Execute stage of the five-stage RV32 pipeline: sits between decode and the memory stage. Computes the ALU result from decoded operands, runs multi-cycle multiply/divide through an iterative unit with a stall handshake, and registers the result plus control into the EX/MEM pipeline register that feeds the memory stage. It also exposes the EX-stage bypass value for forwarding.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 rtl/execute_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RV32 execute stage.
//   XLEN        datapath width
//   alu_op_e    ALU_OP encoding (codes 11..15 are M-extension ops)
//   md_state_e  iterative multiply/divide FSM states
//   is_m_op     predicate: ALU_OP selects the iterative unit
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SLL    = 4'd2,
        OP_SLT    = 4'd3,
        OP_SLTU   = 4'd4,
        OP_XOR    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_OR     = 4'd8,
        OP_AND    = 4'd9,
        OP_PASS_B = 4'd10,
        OP_MUL    = 4'd11,
        OP_MULH   = 4'd12,
        OP_DIV    = 4'd13,
        OP_DIVU   = 4'd14,
        OP_REM    = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_m_op(input logic [3:0] op);
        return (op >= 4'd11);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide for the execute stage.
// Only compiled when RV32M_EN is defined.
//   clk, rst          clock, asynchronous active-low reset
//   op                ALU_OP code (MUL, MULH, DIV, DIVU, REM)
//   a, b              operands, latched on start
//   start             begin an operation (accepted only when idle)
//   flush             abandon any operation, return to idle
//   busy              iteration in progress
//   done              result valid this cycle (one cycle)
//   result            final result, meaningful while done
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// MD_ITER steps. Signed ops run on magnitudes; the sign is fixed up in DONE.
`ifdef RV32M_EN
module muldiv_unit #(
    parameter int unsigned XLEN    = alu_pkg::XLEN,
    parameter int unsigned MD_ITER = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            start,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import alu_pkg::*;

    localparam int unsigned CW = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    alu_op_e         op_q, op_d;
    logic            neg_q, neg_d;          // sign of product / quotient
    logic            rem_neg_q, rem_neg_d;  // remainder takes dividend sign
    logic            bzero_q, bzero_d;
    // hi: product high / remainder, lo: product low / quotient,
    // opb: multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;

    logic            is_signed, a_neg, b_neg;
    logic [XLEN:0]   sum, shifted;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;

        is_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg     = is_signed & a[XLEN-1];
        b_neg     = is_signed & b[XLEN-1];
        sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        shifted   = {hi_q, lo_q[XLEN-1]};

        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        state_d   = MD_BUSY;
                        count_d   = '0;
                        op_d      = alu_op_e'(op);
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        bzero_d   = (b == '0);
                        hi_d      = '0;
                        lo_d      = a_neg ? -a : a;
                        opb_d     = b_neg ? -b : b;
                    end
                end
                MD_BUSY: begin
                    if (op_q == OP_MUL || op_q == OP_MULH) begin
                        hi_d = sum[XLEN:1];
                        lo_d = {sum[0], lo_q[XLEN-1:1]};
                    end else if (shifted < {1'b0, opb_q}) begin
                        hi_d = shifted[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end else begin
                        hi_d = XLEN'(shifted - {1'b0, opb_q});
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(MD_ITER - 1)) begin
                        state_d = MD_DONE;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            op_q      <= OP_ADD;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
        end
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);

    always_comb begin
        case (op_q)
            OP_MUL:  result = lo_q;
            // high half of the negated 2*XLEN product: ~hi plus carry out of ~lo+1
            OP_MULH: result = neg_q ? (~hi_q + XLEN'(lo_q == '0)) : hi_q;
            OP_DIV:  result = bzero_q ? '1 : (neg_q ? -lo_q : lo_q);
            OP_DIVU: result = lo_q;
            OP_REM:  result = rem_neg_q ? -hi_q : hi_q;
            default: result = '0;
        endcase
    end

endmodule
`endif

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the five-stage RV32 pipeline.
// Combinational ALU, optional iterative mul/div (RV32M_EN), EX/MEM register.
//   clk, rst                      clock, asynchronous active-low reset
//   VALID_E, FLUSH                instruction present / kill EX contents
//   SRC_A, SRC_B, ALU_OP          forwarded operands and operation
//   RD_E, WB_WE_E, MEM_WE_E,
//   MEM_REG_E, WD_E               control and store data from decode
//   ALU_OUT, RD, ME_WE, MEM_WE,
//   MEM_REG, WD_ME                registered outputs to the memory stage
//   BP_EX                         value ALU_OUT will load at the next edge
//   STALL                         hold decode while mul/div runs
// RV32M_EN defined: M ops (codes 11..15) use muldiv_unit with stalling.
// RV32M_EN undefined: M ops give ALU_OUT=0, ME_WE=0 in one cycle; STALL=0.
module execute_stage #(
    parameter int unsigned XLEN    = alu_pkg::XLEN,
    parameter int unsigned MD_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            VALID_E,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic [3:0]      ALU_OP,
    input  logic [4:0]      RD_E,
    input  logic            WB_WE_E,
    input  logic            MEM_WE_E,
    input  logic            MEM_REG_E,
    input  logic [XLEN-1:0] WD_E,
    output logic [XLEN-1:0] ALU_OUT,
    output logic [4:0]      RD,
    output logic            ME_WE,
    output logic            MEM_WE,
    output logic            MEM_REG,
    output logic [XLEN-1:0] WD_ME,
    output logic [XLEN-1:0] BP_EX,
    output logic            STALL
);
    import alu_pkg::*;

    localparam int unsigned SW = $clog2(XLEN);

    // the iterative unit runs one bit per step, so it needs exactly XLEN steps
    if (MD_ITER != XLEN) begin : g_cfg_check
        $error("execute_stage: MD_ITER must equal XLEN");
    end

    logic            m_op, stall, kill, wb_ok;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res, ex_res;
    logic [XLEN-1:0] nxt_alu, nxt_wd;
    logic [4:0]      nxt_rd;
    logic            nxt_me_we, nxt_mem_we, nxt_mem_reg;

`ifdef RV32M_EN
    logic            md_busy, md_done, md_idle, md_start;
    logic [XLEN-1:0] md_result;

    muldiv_unit #(
        .XLEN    (XLEN),
        .MD_ITER (MD_ITER)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .op     (ALU_OP),
        .a      (SRC_A),
        .b      (SRC_B),
        .start  (md_start),
        .flush  (FLUSH),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_comb begin
        shamt = SRC_B[SW-1:0];
        case (alu_op_e'(ALU_OP))
            OP_ADD:    alu_res = SRC_A + SRC_B;
            OP_SUB:    alu_res = SRC_A - SRC_B;
            OP_SLL:    alu_res = SRC_A << shamt;
            OP_SLT:    alu_res = XLEN'($signed(SRC_A) < $signed(SRC_B));
            OP_SLTU:   alu_res = XLEN'(SRC_A < SRC_B);
            OP_XOR:    alu_res = SRC_A ^ SRC_B;
            OP_SRL:    alu_res = SRC_A >> shamt;
            OP_SRA:    alu_res = $unsigned($signed(SRC_A) >>> shamt);
            OP_OR:     alu_res = SRC_A | SRC_B;
            OP_AND:    alu_res = SRC_A & SRC_B;
            OP_PASS_B: alu_res = SRC_B;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        m_op = is_m_op(ALU_OP);
`ifdef RV32M_EN
        md_idle  = !md_busy && !md_done;
        md_start = VALID_E && m_op && !FLUSH && md_idle;
        // rst gating keeps STALL low while held in reset with an M op present
        stall    = rst && !FLUSH && ((md_idle && VALID_E && m_op) || md_busy);
        ex_res   = md_done ? md_result : alu_res;
        wb_ok    = 1'b1;
`else
        stall    = 1'b0;
        ex_res   = m_op ? '0 : alu_res;
        wb_ok    = !m_op;
`endif
        kill        = !rst || !VALID_E || FLUSH || stall;
        nxt_alu     = kill ? '0 : ex_res;
        nxt_wd      = kill ? '0 : WD_E;
        nxt_rd      = kill ? '0 : RD_E;
        nxt_me_we   = !kill && WB_WE_E && wb_ok;
        nxt_mem_we  = !kill && MEM_WE_E;
        nxt_mem_reg = !kill && MEM_REG_E;
    end

    assign STALL = stall;
    assign BP_EX = nxt_alu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALU_OUT <= '0;
            WD_ME   <= '0;
            RD      <= '0;
            ME_WE   <= 1'b0;
            MEM_WE  <= 1'b0;
            MEM_REG <= 1'b0;
        end else begin
            ALU_OUT <= nxt_alu;
            WD_ME   <= nxt_wd;
            RD      <= nxt_rd;
            ME_WE   <= nxt_me_we;
            MEM_WE  <= nxt_mem_we;
            MEM_REG <= nxt_mem_reg;
        end
    end

endmodule
